// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: borrows the shared EX-stage ALU one op per cycle.
// Shift-add MUL, restoring DIV/REM with magnitude pre-pass and sign fix-up pass.
package muldiv_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;
endpackage

module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output alu_op_t         alu_op,
  input  logic [XLEN-1:0] alu_result
);

  typedef enum logic [2:0] {IDLE, PRE_A, PRE_B, ITER, POST, FIN} state_t;

  state_t          state, state_nxt;
  logic [4:0]      cnt;
  // a_q: acc / partial remainder, b_q: multiplicand / divisor, c_q: multiplier / dividend
  logic [XLEN-1:0] a_q, b_q, c_q, q_q;
  logic            mul_q, rem_q, sgn_q, err_q, neg_q, neg_r;

  logic            accept, unsup, in_sgn, dz, ovf, fast;
  logic [XLEN-1:0] fast_val;
  logic [XLEN-1:0] r_sh, rem_nxt, quo_nxt, acc_nxt;
  logic            take;
  logic            res_ld;
  logic [XLEN-1:0] res_val;

  assign busy   = (state != IDLE) && (state != FIN);
  assign done   = (state == FIN) && !kill;
  assign err    = done && err_q;
  assign accept = start && !kill && !busy;

  assign unsup  = (op == 3'b001) || (op == 3'b010) || (op == 3'b011);
  assign in_sgn = op[2] && !op[0];
  assign dz     = (rs2 == '0);
  assign ovf    = in_sgn && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == {XLEN{1'b1}});
  assign fast   = unsup || (op[2] && (dz || ovf));

  always_comb begin
    fast_val = '0;
    if (!unsup && dz)
      fast_val = op[1] ? rs1 : {XLEN{1'b1}};
    else if (!unsup && ovf)
      fast_val = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // Carry out of the shifted remainder means it already exceeds any XLEN-bit divisor.
  assign r_sh    = {a_q[XLEN-2:0], c_q[XLEN-1]};
  assign take    = a_q[XLEN-1] || (r_sh >= b_q);
  assign rem_nxt = take ? alu_result : r_sh;
  assign quo_nxt = {q_q[XLEN-2:0], take};
  assign acc_nxt = c_q[0] ? alu_result : a_q;

  // ALU drive is kept apart from anything that reads alu_result back.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    case (state)
      PRE_A: begin
        alu_b  = c_q;
        alu_op = c_q[XLEN-1] ? ALU_SUB : ALU_ADD;
      end
      PRE_B: begin
        alu_b  = b_q;
        alu_op = b_q[XLEN-1] ? ALU_SUB : ALU_ADD;
      end
      ITER: begin
        alu_b = b_q;
        if (mul_q) begin
          alu_a  = a_q;
          alu_op = ALU_ADD;
        end else begin
          alu_a  = r_sh;
          alu_op = ALU_SUB;
        end
      end
      POST: begin
        alu_b  = rem_q ? a_q : q_q;
        alu_op = (rem_q ? neg_r : neg_q) ? ALU_SUB : ALU_ADD;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    res_ld    = 1'b0;
    res_val   = '0;
    case (state)
      IDLE, FIN: begin
        state_nxt = IDLE;
        if (accept) begin
          state_nxt = fast ? FIN : (in_sgn ? PRE_A : ITER);
          res_ld    = fast;
          res_val   = fast_val;
        end
      end
      PRE_A: state_nxt = PRE_B;
      PRE_B: state_nxt = ITER;
      ITER: begin
        if (cnt == 5'd31) begin
          if (sgn_q) begin
            state_nxt = POST;
          end else begin
            state_nxt = FIN;
            res_ld    = 1'b1;
            res_val   = mul_q ? acc_nxt : (rem_q ? rem_nxt : quo_nxt);
          end
        end
      end
      POST: begin
        state_nxt = FIN;
        res_ld    = 1'b1;
        res_val   = alu_result;
      end
      default: state_nxt = IDLE;
    endcase
    if (kill) begin
      state_nxt = IDLE;
      res_ld    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      q_q   <= '0;
      mul_q <= 1'b0;
      rem_q <= 1'b0;
      sgn_q <= 1'b0;
      err_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (res_ld)
        result <= res_val;
      case (state)
        IDLE, FIN: begin
          if (accept) begin
            cnt   <= '0;
            a_q   <= '0;
            q_q   <= '0;
            b_q   <= (op == 3'b000) ? rs1 : rs2;
            c_q   <= (op == 3'b000) ? rs2 : rs1;
            mul_q <= (op == 3'b000);
            rem_q <= op[1];
            sgn_q <= in_sgn;
            err_q <= unsup;
            neg_q <= rs1[XLEN-1] ^ rs2[XLEN-1];
            neg_r <= rs1[XLEN-1];
          end
        end
        PRE_A: c_q <= alu_result;
        PRE_B: b_q <= alu_result;
        ITER: begin
          cnt <= cnt + 5'd1;
          if (mul_q) begin
            a_q <= acc_nxt;
            b_q <= b_q << 1;
            c_q <= c_q >> 1;
          end else begin
            a_q <= rem_nxt;
            c_q <= c_q << 1;
            q_q <= quo_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer implementing RV32M MUL/DIV/DIVU/REM/REMU by driving the shared 32-bit ALU one operation per cycle.
- Sits beside the EX stage. While busy=1, the EX-stage ALU operand/op mux selects alu_a/alu_b/alu_op from this block, and alu_result is fed back combinationally.
- Shift-add multiply, restoring divide, and sign fix-up via ALU negation.

Parameters:
XLEN, 32, datapath width; iteration count equals XLEN.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
op  input  3  RV32M funct3: 000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  input  XLEN  operand A / dividend
rs2  input  XLEN  operand B / divisor
kill  input  1  synchronous abort (pipeline flush)
busy  output  1  operation in progress
done  output  1  one-cycle pulse, result valid
err  output  1  one-cycle pulse with done for unsupported op (001/010/011)
result  output  XLEN  registered result, held until next done
alu_a  output  XLEN  ALU operand a
alu_b  output  XLEN  ALU operand b
alu_op  output  alu_op_t  ALU operation
alu_result  input  XLEN  ALU result, same cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, err=0, result=0. All internal registers clear.
- ALU drive when in IDLE: alu_a=0, alu_b=0, alu_op=ALU_ADD.
- States: IDLE, PRE_A, PRE_B, ITER, POST, FIN. busy=1 in every state except IDLE and FIN.
- Start accepted at edge T (state IDLE, start=1). start while busy is ignored. start in the FIN cycle is accepted.
- Fast path (decided at T; FIN at T+1, no ALU use):
  - unsupported op: result=0, err=1
  - divisor==0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result rs1
  - DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF: DIV result 0x80000000, REM result 0
- MUL, DIVU, REMU: ITER for cycles T+1..T+32; FIN (done=1) at T+33.
- DIV, REM: PRE_A at T+1, PRE_B at T+2, ITER T+3..T+34, POST T+35, FIN T+36. Fixed latency regardless of operand signs.
- PRE_A / PRE_B: alu_a=0, alu_b=operand, alu_op=ALU_SUB if operand[31] else ALU_ADD; latch alu_result as the magnitude.
- MUL ITER, per cycle:
  - alu_a=acc, alu_b=mcand, alu_op=ALU_ADD
  - if mplier[0]: acc<=alu_result
  - then mcand<<=1, mplier>>=1
  - result = acc, low 32 bits.
- DIV ITER, per cycle:
  - r_sh = {rem[30:0], dvd[31]}, carry = rem[31]; dvd<<=1
  - alu_a=r_sh, alu_b=divisor, alu_op=ALU_SUB
  - if carry or r_sh>=divisor (internal unsigned compare): rem<=alu_result and shift 1 into quotient; else rem<=r_sh and shift in 0.
- POST: alu_a=0, alu_b=quotient (DIV) or remainder (REM), alu_op=ALU_SUB when negation is required, else ALU_ADD.
  - quotient negated iff rs1[31]^rs2[31]
  - remainder negated iff rs1[31]
- FIN: done=1, result register loaded on entry. Next state IDLE, or accept start.
- Iteration counter: 5 bits, counts 0..31; ITER exits when it reaches 31.
- kill=1 in any state: next state IDLE, no done or err. result is unchanged. kill has priority over start in the same cycle.
- Mid-operation reset: immediate asynchronous return to the reset values above.

Test Plan:
- MUL rs1=10, rs2=20 → result=200, done exactly at T+33. alu_op=ALU_ADD throughout ITER. busy high T+1..T+32.
- DIVU 100/7 → 14 and REMU → 2, both at T+33. MUL 0xFFFFFFFF*0xFFFFFFFF → 0x00000001.
- DIV -100/7 → 0xFFFFFFF2 and REM → 0xFFFFFFFE at T+36. DIV 100/-7 → 0xFFFFFFF2 with REM → 2.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0. All at T+1. op=010 → err=1, result=0 at T+1.
- Start DIVU, kill at the 10th ITER cycle → busy=0 next cycle, no done, result unchanged. start pulsed while busy is ignored. Back-to-back start in the FIN cycle is accepted.
- rst_n low during ITER → busy, done, result immediately 0. After release, MUL 3*4 → 12 at T+33.
